pwm_ctrl: RTL

- Motor PWM generator directly downstream of the PID angle controller.
- Consumes the controller's pwm_update / pwm_ratio / pwm_direction request and produces the motor drive pwm_out / dir_out.
- Returns the pwm_done indication once a requested ratio is actually being driven.
- New ratios are applied only at PWM period boundaries (glitch-free); direction reversals insert a dead time of forced-low periods.

---
 rtl/pwm_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_ctrl.sv
// pwm_ctrl
//    Motor PWM generator sitting after the PID angle controller. A requested
//    ratio/direction is captured whenever pwm_update is high and only takes
//    effect at a PWM period boundary, so the drive waveform never glitches.
//    A direction reversal first runs DEADTIME_PERIODS full periods with the
//    drive forced low, then flips dir_out together with the new ratio.
//
// Ports
//    clock          main clock
//    reset_n        asynchronous active-low reset
//    pwm_enable     run enable; low forces IDLE and drops any pending request
//    pwm_update     request strobe/level; pwm_ratio and pwm_direction valid while high
//    pwm_ratio      requested high time out of 255 PWM ticks
//    pwm_direction  requested motor direction
//    pwm_out        registered PWM drive
//    dir_out        registered applied direction
//    pwm_done       one-cycle pulse once a requested ratio is being driven
//    active_ratio   ratio currently driven
//    state          debug view of the controller state (00 IDLE, 01 RUN, 10 DEAD)

module pwm_ctrl #(
   parameter int PRESCALE         = 4,
   parameter int DEADTIME_PERIODS = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       pwm_enable,
   input  logic       pwm_update,
   input  logic [7:0] pwm_ratio,
   input  logic       pwm_direction,
   output logic       pwm_out,
   output logic       dir_out,
   output logic       pwm_done,
   output logic [7:0] active_ratio,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DEAD = 2'b10
   } state_t;

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_PERIODS - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic [7:0]    per_cnt_q, per_cnt_d;
   logic [DW-1:0] dead_cnt_q, dead_cnt_d;
   logic [7:0]    pend_ratio_q, pend_ratio_d;
   logic          pend_dir_q, pend_dir_d;
   logic          pending_q, pending_d;
   logic [7:0]    active_ratio_q, active_ratio_d;
   logic          dir_q, dir_d;
   logic          pwm_q, pwm_d;
   logic          done_q, done_d;

   logic          tick;
   logic          boundary;
   logic          req_valid;
   logic [7:0]    req_ratio;
   logic          req_dir;

   // Timing strobes and the effective request. A request arriving in the
   // boundary cycle itself bypasses the pending registers so it is not
   // delayed by a whole period.
   always_comb begin
      tick      = (state_q != ST_IDLE) && (pre_cnt_q == PRE_LAST);
      boundary  = tick && (per_cnt_q == 8'd254);
      req_valid = pending_q || pwm_update;
      req_ratio = pwm_update ? pwm_ratio     : pend_ratio_q;
      req_dir   = pwm_update ? pwm_direction : pend_dir_q;
   end

   // Next-state logic. Captures and counter advance are computed first as
   // defaults, then the state-specific decisions override them, and finally
   // a low pwm_enable overrides everything outside IDLE.
   always_comb begin
      state_d        = state_q;
      pre_cnt_d      = pre_cnt_q;
      per_cnt_d      = per_cnt_q;
      dead_cnt_d     = dead_cnt_q;
      pend_ratio_d   = pend_ratio_q;
      pend_dir_d     = pend_dir_q;
      pending_d      = pending_q;
      active_ratio_d = active_ratio_q;
      dir_d          = dir_q;
      done_d         = 1'b0;
      pwm_d          = (state_q == ST_RUN) && pwm_enable && (per_cnt_q < active_ratio_q);

      if (pwm_update) begin
         pend_ratio_d = pwm_ratio;
         pend_dir_d   = pwm_direction;
         pending_d    = 1'b1;
      end

      if (state_q != ST_IDLE) begin
         if (tick) begin
            pre_cnt_d = '0;
            per_cnt_d = (per_cnt_q == 8'd254) ? 8'd0 : per_cnt_q + 8'd1;
         end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            pre_cnt_d      = '0;
            per_cnt_d      = 8'd0;
            dead_cnt_d     = '0;
            active_ratio_d = 8'd0;
            if (pwm_enable) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (boundary && req_valid) begin
               // Same direction, or a stopped motor, can switch immediately.
               if ((req_dir == dir_q) || (active_ratio_q == 8'd0)) begin
                  active_ratio_d = req_ratio;
                  dir_d          = req_dir;
                  pending_d      = 1'b0;
                  done_d         = 1'b1;
               end else begin
                  state_d    = ST_DEAD;
                  dead_cnt_d = '0;
               end
            end
         end
         ST_DEAD: begin
            if (boundary) begin
               if (dead_cnt_q == DEAD_LAST) begin
                  active_ratio_d = req_ratio;
                  dir_d          = req_dir;
                  pending_d      = 1'b0;
                  done_d         = 1'b1;
                  state_d        = ST_RUN;
               end else begin
                  dead_cnt_d = dead_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (!pwm_enable && (state_q != ST_IDLE)) begin
         state_d        = ST_IDLE;
         pre_cnt_d      = '0;
         per_cnt_d      = 8'd0;
         dead_cnt_d     = '0;
         pend_ratio_d   = pend_ratio_q;
         pend_dir_d     = pend_dir_q;
         pending_d      = 1'b0;
         active_ratio_d = 8'd0;
         dir_d          = dir_q;
         done_d         = 1'b0;
         pwm_d          = 1'b0;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         pre_cnt_q      <= '0;
         per_cnt_q      <= 8'd0;
         dead_cnt_q     <= '0;
         pend_ratio_q   <= 8'd0;
         pend_dir_q     <= 1'b0;
         pending_q      <= 1'b0;
         active_ratio_q <= 8'd0;
         dir_q          <= 1'b0;
         pwm_q          <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pre_cnt_q      <= pre_cnt_d;
         per_cnt_q      <= per_cnt_d;
         dead_cnt_q     <= dead_cnt_d;
         pend_ratio_q   <= pend_ratio_d;
         pend_dir_q     <= pend_dir_d;
         pending_q      <= pending_d;
         active_ratio_q <= active_ratio_d;
         dir_q          <= dir_d;
         pwm_q          <= pwm_d;
         done_q         <= done_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign dir_out      = dir_q;
   assign pwm_done     = done_q;
   assign active_ratio = active_ratio_q;
   assign state        = state_q;

endmodule
